// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ writeback requesters, with a watchdog on the register file's reg_ack.
module regfile_write_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16,
    parameter int ACK_TIMEOUT = 8,
    localparam int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        write_en,
    output logic [ADDR_W-1:0]           write_addr,
    output logic [DATA_W-1:0]           write_data,
    input  logic                        reg_ack,
    output logic [GID_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        err_timeout
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]        state;
    logic [GID_W-1:0]  last;
    logic [CNT_W-1:0]  cnt;

    logic              found;
    logic [GID_W-1:0]  pick;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;
    int                cand;

    assign busy = (state != IDLE);

    // Search last+1, last+2, ... (wrapping) and take the first valid requester.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        found     = 1'b0;
        pick      = last;
        pick_addr = '0;
        pick_data = '0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == cand) && req_valid[i]) begin
                    found     = 1'b1;
                    pick      = GID_W'(i);
                    pick_addr = req_addr[i*ADDR_W +: ADDR_W];
                    pick_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ack     <= '0;
            write_en    <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            last        <= GID_W'(NUM_REQ - 1);
            cnt         <= '0;
        end else begin
            req_ack  <= '0;
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        write_addr <= pick_addr;
                        write_data <= pick_data;
                        grant_id   <= pick;
                        write_en   <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    cnt   <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // A missing reg_ack still completes the transaction so the
                    // requester is never left hanging; the sticky flag records it.
                    if (reg_ack) begin
                        req_ack <= NUM_REQ'(1) << grant_id;
                        state   <= DONE;
                    end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        req_ack     <= NUM_REQ'(1) << grant_id;
                        err_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    last  <= grant_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued when a
// request is driven and popped when write_en appears.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 16;
    localparam int ACK_TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      write_en;
    logic [ADDR_W-1:0]         write_addr;
    logic [DATA_W-1:0]         write_data;
    logic                      reg_ack;
    logic [0:0]                grant_id;
    logic                      busy;
    logic                      err_timeout;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [0:0]        gid;
    } wr_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;
    bit  ack_en = 1'b1;
    bit  ack_pending = 1'b0;
    bit  spur_ack = 1'b0;
    int  lat;

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ack(req_ack), .write_en(write_en),
        .write_addr(write_addr), .write_data(write_data), .reg_ack(reg_ack),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the register-file model answers the cycle after write_en.
    task automatic tick();
        @(posedge clk);
        #1;
        reg_ack     = ack_pending || spur_ack;
        spur_ack    = 1'b0;
        ack_pending = ack_en && (write_en === 1'b1);
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[i]                = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [0:0] g);
        wr_t w;
        w.addr = a; w.data = d; w.gid = g;
        sb.push_back(w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for write_en and compares the port against the oldest queued write.
    task automatic expect_write(input string tag, output int n);
        wr_t w;
        n = 0;
        while (write_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (write_en !== 1'b1) begin
            check({tag, "_we_seen"}, 32'(write_en), 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            w = sb.pop_front();
            check({tag, "_addr"}, 32'(write_addr), 32'(w.addr));
            check({tag, "_data"}, 32'(write_data), 32'(w.data));
            check({tag, "_gid"},  32'(grant_id),   32'(w.gid));
        end
    endtask

    task automatic expect_ack(input string tag, input logic [NUM_REQ-1:0] exp, output int n);
        n = 0;
        tick();
        n++;
        while (req_ack === '0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_ack"}, 32'(req_ack), 32'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        reg_ack   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset state
        do_reset();
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_we", 32'(write_en), 32'd0);
        check("rst_addr", 32'(write_addr), 32'd0);
        check("rst_data", 32'(write_data), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Single write with nominal latency
        set_req(0, 1'b1, 4'd3, 16'hBEEF);
        push(4'd3, 16'hBEEF, 1'b0);
        expect_write("single", lat);
        check("single_we_lat", 32'(lat), 32'd1);
        expect_ack("single", 2'b01, lat);
        check("single_ack_lat", 32'(lat), 32'd2);
        req_valid = '0;
        tick();
        check("single_busy_low", 32'(busy), 32'd0);
        check("single_ack_pulse", 32'(req_ack), 32'd0);
        check("single_err", 32'(err_timeout), 32'd0);

        // Contention right after reset: requester 0 has first priority
        do_reset();
        set_req(0, 1'b1, 4'd1, 16'h1111);
        set_req(1, 1'b1, 4'd2, 16'h2222);
        push(4'd1, 16'h1111, 1'b0);
        push(4'd2, 16'h2222, 1'b1);
        expect_write("cont0", lat);
        expect_ack("cont0", 2'b01, lat);
        req_valid[0] = 1'b0;
        expect_write("cont1", lat);
        check("cont1_gap", 32'(lat), 32'd2);
        expect_ack("cont1", 2'b10, lat);
        req_valid = '0;

        // Fairness: both valid continuously, each re-presenting after its ack
        for (int k = 0; k < 6; k++)
            push(4'((k % 2) * 8 + k / 2), 16'h3000 | 16'((k % 2) << 8) | 16'(k / 2), 1'(k % 2));
        set_req(0, 1'b1, 4'd0, 16'h3000);
        set_req(1, 1'b1, 4'd8, 16'h3100);
        for (int k = 0; k < 6; k++) begin
            expect_write($sformatf("fair%0d", k), lat);
            if (k > 0) check($sformatf("fair%0d_gap", k), 32'(lat), 32'd2);
            expect_ack($sformatf("fair%0d", k), 2'(1 << (k % 2)), lat);
            set_req(k % 2, 1'b1, 4'((k % 2) * 8 + k / 2 + 1),
                    16'h3000 | 16'((k % 2) << 8) | 16'(k / 2 + 1));
        end
        req_valid = '0;
        tick();

        // Watchdog: no reg_ack, completion ACK_TIMEOUT+1 cycles after write_en
        ack_en = 1'b0;
        set_req(0, 1'b1, 4'd7, 16'h7777);
        push(4'd7, 16'h7777, 1'b0);
        expect_write("tmo", lat);
        expect_ack("tmo", 2'b01, lat);
        check("tmo_lat", 32'(lat), 32'(ACK_TIMEOUT + 1));
        check("tmo_err", 32'(err_timeout), 32'd1);
        req_valid = '0;
        ack_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(1, 1'b1, 4'(10 + k), 16'hA000 + 16'(k));
            push(4'(10 + k), 16'hA000 + 16'(k), 1'b1);
            expect_write($sformatf("sticky%0d", k), lat);
            expect_ack($sformatf("sticky%0d", k), 2'b10, lat);
            check($sformatf("sticky%0d_lat", k), 32'(lat), 32'd2);
            req_valid = '0;
            check($sformatf("sticky%0d_err", k), 32'(err_timeout), 32'd1);
        end
        do_reset();
        check("err_cleared", 32'(err_timeout), 32'd0);

        // Reset during WAIT_ACK abandons the write
        ack_en = 1'b0;
        set_req(0, 1'b1, 4'd9, 16'h9999);
        push(4'd9, 16'h9999, 1'b0);
        expect_write("mid", lat);
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy_rst", 32'(busy), 32'd0);
        check("mid_we_rst", 32'(write_en), 32'd0);
        check("mid_addr_rst", 32'(write_addr), 32'd0);
        check("mid_data_rst", 32'(write_data), 32'd0);
        check("mid_gid_rst", 32'(grant_id), 32'd0);
        check("mid_ack_rst", 32'(req_ack), 32'd0);
        ack_en = 1'b1;
        tick();
        check("mid_no_ack", 32'(req_ack), 32'd0);
        set_req(1, 1'b1, 4'd5, 16'h5555);
        push(4'd5, 16'h5555, 1'b1);
        expect_write("reissue", lat);
        expect_ack("reissue", 2'b10, lat);
        req_valid = '0;
        tick();

        // Spurious reg_ack while idle is ignored
        spur_ack = 1'b1;
        tick();
        tick();
        check("spur_ack", 32'(req_ack), 32'd0);
        check("spur_busy", 32'(busy), 32'd0);
        set_req(0, 1'b1, 4'd4, 16'h4444);
        push(4'd4, 16'h4444, 1'b0);
        expect_write("post_spur", lat);
        check("post_spur_we_lat", 32'(lat), 32'd1);
        expect_ack("post_spur", 2'b01, lat);
        check("post_spur_ack_lat", 32'(lat), 32'd2);
        req_valid = '0;
        tick();
        check("post_spur_idle", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
